// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
//   - state_t     : controller FSM states
//   - alu_op_t    : coarse ALU request from the FSM to the ALU decoder
//   - OP_* / FN_* : opcode and R-type funct field values
//   - ALUC_*      : ALUControl codes driven to the datapath ALU
//   - SRCB_* / PCSRC_* : ALUSrcB and PCSrc mux encodings
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_alu_decoder.sv
// ALU decoder for the multicycle controller.
//   alu_op        in  : ADD / SUB request, or FUNCT to decode the funct field
//   funct         in  : Instr[5:0]
//   alu_control   out : ALUControl code for the datapath ALU
//   funct_illegal out : funct is not a supported R-type operation. Depends on
//                       funct alone so the FSM can read it in the same
//                       combinational block that drives alu_op; it only has
//                       meaning while the FSM is executing an R-type.
module mips_mc_alu_decoder
  import mips_mc_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int ALUC_W = 3
) (
  input  alu_op_t           alu_op,
  input  logic [OP_W-1:0]   funct,
  output logic [ALUC_W-1:0] alu_control,
  output logic              funct_illegal
);

  logic [ALUC_W-1:0] funct_code;

  always_comb begin
    // NOTE: assign every output a default before the case so no path
    // leaves it unassigned, which would infer a latch.
    funct_code    = ALUC_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  funct_code = ALUC_ADD;
      FN_SUB:  funct_code = ALUC_SUB;
      FN_AND:  funct_code = ALUC_AND;
      FN_OR:   funct_code = ALUC_OR;
      FN_SLT:  funct_code = ALUC_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALUOP_SUB:   alu_control = ALUC_SUB;
      ALUOP_FUNCT: alu_control = funct_code;
      default:     alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore-style control FSM for a multicycle MIPS datapath (shared ALU,
// unified memory, instruction register).
//   CLK, RST            : clock, synchronous active-high reset
//   Opcode, Funct       : instruction register fields
//   ZeroFlag            : ALU zero flag (used in BRANCH)
//   MemReady            : memory finishes the current access this cycle
//   MemReq, IorD, MemWrite, IRWrite        : memory / IR control
//   PCEn, PCSrc                            : PC update control
//   ALUSrcA, ALUSrcB, ALUControl           : ALU operand / operation select
//   RegDst, Mem2Reg, RegWrite              : register file writeback control
//   IllegalOp           : one-cycle pulse on unsupported opcode or funct
// Optional build macro MIPS_MC_PERF_CNT_EN adds CycleCnt / InstrCnt
// performance counters (both clear on RST and wrap at 2^32).
module mips_multicycle_controller
  import mips_mc_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int ALUC_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [OP_W-1:0]   Opcode,
  input  logic [OP_W-1:0]   Funct,
  input  logic              ZeroFlag,
  input  logic              MemReady,
  output logic              MemReq,
  output logic              IorD,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              PCEn,
  output logic [1:0]        PCSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              RegDst,
  output logic              Mem2Reg,
  output logic              RegWrite,
  output logic              IllegalOp
`ifdef MIPS_MC_PERF_CNT_EN
  ,
  output logic [31:0]       CycleCnt,
  output logic [31:0]       InstrCnt
`endif
);

  state_t  state, next_state;
  alu_op_t alu_op;
  logic    pc_write;
  logic    branch;
  logic    funct_illegal;

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (RST) state <= S_FETCH;
    else     state <= next_state;
  end

  mips_mc_alu_decoder #(
    .OP_W   (OP_W),
    .ALUC_W (ALUC_W)
  ) u_alu_decoder (
    .alu_op        (alu_op),
    .funct         (Funct),
    .alu_control   (ALUControl),
    .funct_illegal (funct_illegal)
  );

  // Branch only redirects the PC when the comparison came out equal.
  assign PCEn = pc_write | (branch & ZeroFlag);

  always_comb begin
    next_state = state;
    MemReq     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    PCSrc      = PCSRC_ALU;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    alu_op     = ALUOP_ADD;
    RegDst     = 1'b0;
    Mem2Reg    = 1'b0;
    RegWrite   = 1'b0;
    IllegalOp  = 1'b0;

    // While in reset everything stays at the defaults, so a write in flight
    // is dropped in the very cycle RST rises.
    if (!RST) begin
      case (state)
        S_FETCH: begin
          MemReq  = 1'b1;
          ALUSrcB = SRCB_FOUR;
          if (MemReady) begin
            IRWrite    = 1'b1;
            pc_write   = 1'b1;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          // Precompute the branch target into ALUOut.
          ALUSrcB = SRCB_IMM_SH;
          case (Opcode)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_RTYPE:     next_state = S_EXEC;
            OP_BEQ:       next_state = S_BRANCH;
            OP_ADDI:      next_state = S_ADDIEX;
            OP_J:         next_state = S_JUMP;
            default: begin
              IllegalOp  = 1'b1;
              next_state = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          next_state = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          MemReq = 1'b1;
          IorD   = 1'b1;
          if (MemReady) next_state = S_MEMWB;
        end
        S_MEMWB: begin
          Mem2Reg    = 1'b1;
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWR: begin
          MemReq   = 1'b1;
          IorD     = 1'b1;
          MemWrite = 1'b1;
          if (MemReady) next_state = S_FETCH;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          alu_op  = ALUOP_FUNCT;
          if (funct_illegal) begin
            IllegalOp  = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_ALUWB;
          end
        end
        S_ALUWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          alu_op     = ALUOP_SUB;
          PCSrc      = PCSRC_ALUOUT;
          branch     = 1'b1;
          next_state = S_FETCH;
        end
        S_ADDIEX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          next_state = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_JUMP: begin
          PCSrc      = PCSRC_JUMP;
          pc_write   = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

`ifdef MIPS_MC_PERF_CNT_EN
  // An instruction retires on its last cycle; illegal ops never get here.
  logic retire;
  assign retire = !RST &&
                  ((state inside {S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP}) ||
                   (state == S_MEMWR && MemReady));

  always_ff @(posedge CLK) begin
    if (RST) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else begin
      CycleCnt <= CycleCnt + 32'd1;
      if (retire) InstrCnt <= InstrCnt + 32'd1;
    end
  end
`endif

endmodule
